// File: rtl/mul_div_unit.sv
// RV32M multi-cycle multiply/divide unit: 32-step shift-add multiplier and 32-step
// restoring divider, with sign handling at accept and sign correction in FIX.
module mul_div_unit (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        MDU_start,
    input  logic [2:0]  MDU_funct3,
    input  logic [31:0] MDU_rs1_data,
    input  logic [31:0] MDU_rs2_data,
    output logic        MDU_busy,
    output logic        MDU_done,
    output logic [31:0] MDU_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [31:0] mag1_q, mag1_d;
    logic [31:0] mag2_q, mag2_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        in_signed1, in_signed2, in_sign1, in_sign2;
    logic [31:0] in_mag1, in_mag2;
    logic        div_by_zero, div_overflow, special;
    logic [31:0] special_result;
    logic [63:0] mul_addend;
    logic [33:0] trial;
    logic        prod_neg;
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed, rem_fixed, fix_result;
    logic        do_accept;

    // Operand decode at accept: signedness, magnitudes and special cases
    always_comb begin
        in_signed1  = (MDU_funct3 == 3'b001) || (MDU_funct3 == 3'b010) ||
                      (MDU_funct3 == 3'b100) || (MDU_funct3 == 3'b110);
        in_signed2  = (MDU_funct3 == 3'b001) || (MDU_funct3 == 3'b100) ||
                      (MDU_funct3 == 3'b110);
        in_sign1    = in_signed1 & MDU_rs1_data[31];
        in_sign2    = in_signed2 & MDU_rs2_data[31];
        in_mag1     = in_sign1 ? (32'd0 - MDU_rs1_data) : MDU_rs1_data;
        in_mag2     = in_sign2 ? (32'd0 - MDU_rs2_data) : MDU_rs2_data;
        div_by_zero = MDU_funct3[2] && (MDU_rs2_data == 32'd0);
        div_overflow = ((MDU_funct3 == 3'b100) || (MDU_funct3 == 3'b110)) &&
                       (MDU_rs1_data == 32'h8000_0000) && (MDU_rs2_data == 32'hFFFF_FFFF);
        special     = div_by_zero || div_overflow;
        if (div_by_zero) begin
            special_result = MDU_funct3[1] ? MDU_rs1_data : 32'hFFFF_FFFF;
        end else begin
            special_result = MDU_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Datapath helpers: one multiply/divide step and the final sign correction
    always_comb begin
        mul_addend = mag2_q[cnt_q] ? ({32'd0, mag1_q} << cnt_q) : 64'd0;
        // 34-bit trial keeps the borrow visible even though the shifted remainder is 33 bits
        trial      = {1'b0, rem_q, quo_q[31]} - {2'b00, mag2_q};
        if (funct3_q == 3'b001) begin
            prod_neg = sign1_q ^ sign2_q;
        end else if (funct3_q == 3'b010) begin
            prod_neg = sign1_q;
        end else begin
            prod_neg = 1'b0;
        end
        prod_fixed = prod_neg ? (64'd0 - acc_q) : acc_q;
        quo_fixed  = ((funct3_q == 3'b100) && (sign1_q ^ sign2_q)) ? (32'd0 - quo_q) : quo_q;
        rem_fixed  = ((funct3_q == 3'b110) && sign1_q) ? (32'd0 - rem_q) : rem_q;
        if (funct3_q[2]) begin
            fix_result = funct3_q[1] ? rem_fixed : quo_fixed;
        end else if (funct3_q[1:0] == 2'b00) begin
            fix_result = prod_fixed[31:0];
        end else begin
            fix_result = prod_fixed[63:32];
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        mag1_d    = mag1_q;
        mag2_d    = mag2_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        do_accept = 1'b0;

        case (state_q)
            IDLE: begin
                if (MDU_start) begin
                    do_accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (funct3_q[2]) begin
                    if (!trial[33]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[30:0], quo_q[31]};
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = acc_q + mul_addend;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                result_d = fix_result;
                state_d  = DONE;
            end
            DONE: begin
                if (MDU_start) begin
                    do_accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_accept) begin
            funct3_d = MDU_funct3;
            sign1_d  = in_sign1;
            sign2_d  = in_sign2;
            mag1_d   = in_mag1;
            mag2_d   = in_mag2;
            cnt_d    = 5'd0;
            acc_d    = 64'd0;
            rem_d    = 32'd0;
            quo_d    = in_mag1;
            if (special) begin
                result_d = special_result;
                state_d  = DONE;
            end else begin
                state_d  = CALC;
            end
        end else begin
            funct3_d = funct3_d;
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q  <= IDLE;
            funct3_q <= 3'd0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            mag1_q   <= 32'd0;
            mag2_q   <= 32'd0;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            mag1_q   <= mag1_d;
            mag2_q   <= mag2_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign MDU_busy   = busy_q;
    assign MDU_done   = done_q;
    assign MDU_result = result_q;

endmodule
